// File: rtl/xor_stream_cipher_w_if.sv
// Dual-channel handshake bundle for the W-bit XOR stream cipher.
// slave is the cipher's view; master is the traffic source/sink view.
interface xor_stream_cipher_w_if #(
  parameter int W = 8
);
  logic         tx_in_valid;
  logic         tx_in_ready;
  logic [W-1:0] tx_in_data;
  logic         tx_out_valid;
  logic         tx_out_ready;
  logic [W-1:0] tx_out_data;
  logic         rx_in_valid;
  logic         rx_in_ready;
  logic [W-1:0] rx_in_data;
  logic         rx_out_valid;
  logic         rx_out_ready;
  logic [W-1:0] rx_out_data;

  modport slave (
    input  tx_in_valid, tx_in_data, tx_out_ready,
    output tx_in_ready, tx_out_valid, tx_out_data,
    input  rx_in_valid, rx_in_data, rx_out_ready,
    output rx_in_ready, rx_out_valid, rx_out_data
  );

  modport master (
    output tx_in_valid, tx_in_data, tx_out_ready,
    input  tx_in_ready, tx_out_valid, tx_out_data,
    output rx_in_valid, rx_in_data, rx_out_ready,
    input  rx_in_ready, rx_out_valid, rx_out_data
  );
endinterface

// File: rtl/xor_stream_cipher_w.sv
// W-bit-per-beat dual-channel XOR stream cipher with Galois LFSR keystreams.
// Taps, seed and bypass arrive over a serial cfg chain validated at the load event.
module xor_stream_cipher_w #(
  parameter int           W            = 8,
  parameter int           N            = 32,
  parameter logic [N-1:0] DEFAULT_TAPS = 'h48000000,
  parameter logic [N-1:0] DEFAULT_SEED = 'h00000055
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_en,
  input  logic cfg_i,
  output logic cfg_o,
  input  logic rekey,
  output logic cfg_ok,
  output logic cfg_err,
  xor_stream_cipher_w_if.slave bus
);
  localparam int             CFGW     = 2 * N + 2;
  localparam int             CW       = $clog2(2 * N + 4);
  localparam logic [CW-1:0]  CNT_FULL = CW'(2 * N + 2);
  localparam logic [CW-1:0]  CNT_SAT  = CW'(2 * N + 3);

  logic [CFGW-1:0] r_cfg;
  logic [CW-1:0]   r_cnt;
  logic            r_cfg_ok;
  logic            r_cfg_err;

  logic [N-1:0]    w_taps;
  logic [N-1:0]    w_seed;
  logic            w_bypass;
  logic            w_load_evt;
  logic            w_load_good;
  logic            w_rekey_go;

  logic [1:0]          w_in_valid;
  logic [1:0]          w_in_ready;
  logic [1:0]          w_out_ready;
  logic [1:0]          w_out_valid;
  logic [1:0][W-1:0]   w_in_data;
  logic [1:0][W-1:0]   w_out_data;

  assign w_bypass = r_cfg[CFGW-1];
  assign w_taps   = r_cfg[2*N-1:N];
  assign w_seed   = r_cfg[N-1:0];

  // A nonzero counter with cfg_en low can only mean cfg_en just fell.
  assign w_load_evt  = !cfg_en && (r_cnt != '0);
  assign w_load_good = w_load_evt && (r_cnt == CNT_FULL) && (w_seed != '0);
  assign w_rekey_go  = rekey && !cfg_en && r_cfg_ok;

  assign cfg_o   = cfg_en & r_cfg[0];
  assign cfg_ok  = r_cfg_ok;
  assign cfg_err = r_cfg_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg     <= {2'b00, DEFAULT_TAPS, DEFAULT_SEED};
      r_cnt     <= '0;
      r_cfg_ok  <= 1'b1;
      r_cfg_err <= 1'b0;
    end else if (cfg_en) begin
      r_cfg <= {cfg_i, r_cfg[CFGW-1:1]};
      if (r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (w_load_evt) begin
      r_cnt     <= '0;
      r_cfg_ok  <= w_load_good;
      r_cfg_err <= !w_load_good;
    end
  end

  // Channel 0 is TX (encrypt), channel 1 is RX (decrypt); the datapath is identical.
  assign w_in_valid  = {bus.rx_in_valid, bus.tx_in_valid};
  assign w_in_data   = {bus.rx_in_data, bus.tx_in_data};
  assign w_out_ready = {bus.rx_out_ready, bus.tx_out_ready};

  assign bus.tx_in_ready  = w_in_ready[0];
  assign bus.tx_out_valid = w_out_valid[0];
  assign bus.tx_out_data  = w_out_data[0];
  assign bus.rx_in_ready  = w_in_ready[1];
  assign bus.rx_out_valid = w_out_valid[1];
  assign bus.rx_out_data  = w_out_data[1];

  genvar gi, gb;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [N-1:0]      r_lfsr;
      logic              r_out_valid;
      logic [W-1:0]      r_out_data;
      logic [W:0][N-1:0] w_chain;
      logic [W-1:0]      w_ks;
      logic              w_accept;

      assign w_chain[0] = r_lfsr;
      for (gb = 0; gb < W; gb++) begin : g_step
        assign w_ks[gb]      = w_chain[gb][0];
        assign w_chain[gb+1] = (w_chain[gb] >> 1) ^ (w_chain[gb][0] ? w_taps : '0);
      end

      assign w_in_ready[gi]  = rst_n & r_cfg_ok & !cfg_en & (!r_out_valid | w_out_ready[gi]);
      assign w_accept        = w_in_valid[gi] & w_in_ready[gi];
      assign w_out_valid[gi] = r_out_valid;
      assign w_out_data[gi]  = r_out_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_lfsr      <= DEFAULT_SEED;
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
        end else begin
          // Reseeding wins over the post-beat state of a same-cycle accept.
          if (w_load_good || w_rekey_go) begin
            r_lfsr <= w_seed;
          end else if (w_accept) begin
            r_lfsr <= w_chain[W];
          end

          if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_bypass ? w_in_data[gi] : (w_in_data[gi] ^ w_ks);
          end else if (w_out_ready[gi]) begin
            r_out_valid <= 1'b0;
          end
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_xor_stream_cipher_w.sv
// Directed bench for xor_stream_cipher_w at W=8, N=32 with hand-computed keystream.
module tb_xor_stream_cipher_w;
  logic clk = 1'b0;
  logic rst_n;
  logic cfg_en, cfg_i, cfg_o, rekey, cfg_ok, cfg_err;
  logic lb;
  logic rx_iv, tx_or;
  logic [7:0] rx_id;
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] pt;
    logic [7:0] ct;
  } vec_t;
  vec_t vecs[5];

  xor_stream_cipher_w_if #(.W(8)) bus ();

  assign bus.rx_in_valid  = lb ? bus.tx_out_valid : rx_iv;
  assign bus.rx_in_data   = lb ? bus.tx_out_data  : rx_id;
  assign bus.tx_out_ready = lb ? bus.rx_in_ready  : tx_or;

  xor_stream_cipher_w #(.W(8), .N(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_en  (cfg_en),
    .cfg_i   (cfg_i),
    .cfg_o   (cfg_o),
    .rekey   (rekey),
    .cfg_ok  (cfg_ok),
    .cfg_err (cfg_err),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    lb = 1'b0; cfg_en = 1'b0; cfg_i = 1'b0; rekey = 1'b0;
    bus.tx_in_valid = 1'b0; bus.tx_in_data = '0; tx_or = 1'b0;
    rx_iv = 1'b0; rx_id = '0; bus.rx_out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_tx(input logic [7:0] d, input logic [7:0] e, input logic rk, input string nm);
    int t;
    t = 0;
    @(negedge clk);
    bus.tx_in_valid = 1'b1; bus.tx_in_data = d; tx_or = 1'b1; rekey = rk;
    #1;
    while (!bus.tx_in_ready && t < 20) begin
      @(negedge clk); #1; t++;
    end
    chk({nm, "_ready"}, 64'(bus.tx_in_ready), 64'd1);
    @(posedge clk); #1;
    bus.tx_in_valid = 1'b0; rekey = 1'b0;
    chk({nm, "_valid"}, 64'(bus.tx_out_valid), 64'd1);
    chk(nm, 64'(bus.tx_out_data), 64'(e));
  endtask

  task automatic shift_cfg(input logic [65:0] v, input int n, input int exp_o0, input string nm);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cfg_en = 1'b1; cfg_i = v[i];
      if (i == 0) begin
        #1;
        chk({nm, "_cfg_blocks_ready"}, 64'(bus.tx_in_ready), 64'd0);
        if (exp_o0 >= 0) chk({nm, "_cfg_o"}, 64'(cfg_o), 64'(exp_o0));
      end
    end
    @(negedge clk);
    cfg_en = 1'b0; cfg_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_b;
    int sent, got;
    bit acc;

    vecs[0] = '{pt: 8'h00, ct: 8'h55};
    vecs[1] = '{pt: 8'h00, ct: 8'h00};
    vecs[2] = '{pt: 8'h3C, ct: 8'h3C};
    vecs[3] = '{pt: 8'hFF, ct: 8'h2F};
    vecs[4] = '{pt: 8'h12, ct: 8'h3D};

    // Reset state
    rst_n = 1'b0; lb = 1'b0; cfg_en = 1'b0; cfg_i = 1'b0; rekey = 1'b0;
    bus.tx_in_valid = 1'b0; bus.tx_in_data = '0; tx_or = 1'b1;
    rx_iv = 1'b0; rx_id = '0; bus.rx_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tx_in_ready", 64'(bus.tx_in_ready), 64'd0);
    chk("rst_rx_in_ready", 64'(bus.rx_in_ready), 64'd0);
    chk("rst_tx_out_valid", 64'(bus.tx_out_valid), 64'd0);
    chk("rst_rx_out_valid", 64'(bus.rx_out_valid), 64'd0);
    chk("rst_tx_out_data", 64'(bus.tx_out_data), 64'd0);
    chk("rst_rx_out_data", 64'(bus.rx_out_data), 64'd0);
    chk("rst_cfg_ok", 64'(cfg_ok), 64'd1);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_cfg_o", 64'(cfg_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_tx_in_ready", 64'(bus.tx_in_ready), 64'd1);

    // Table: TX encrypts pt, RX decrypts ct, both channels back-to-back
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.tx_in_valid = 1'b1; bus.tx_in_data = vecs[i].pt; tx_or = 1'b1;
      rx_iv = 1'b1; rx_id = vecs[i].ct; bus.rx_out_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d_tx_ready", i), 64'(bus.tx_in_ready), 64'd1);
      chk($sformatf("vec%0d_rx_ready", i), 64'(bus.rx_in_ready), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_tx_out", i), 64'({bus.tx_out_valid, bus.tx_out_data}), 64'({1'b1, vecs[i].ct}));
      chk($sformatf("vec%0d_rx_out", i), 64'({bus.rx_out_valid, bus.rx_out_data}), 64'({1'b1, vecs[i].pt}));
    end
    bus.tx_in_valid = 1'b0; rx_iv = 1'b0;

    // Backpressure
    do_reset();
    @(negedge clk);
    bus.tx_in_valid = 1'b1; bus.tx_in_data = 8'h11; tx_or = 1'b0;
    #1;
    chk("bp_first_ready", 64'(bus.tx_in_ready), 64'd1);
    @(posedge clk); #1;
    bus.tx_in_data = 8'h22;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("bp_hold%0d_ready", i), 64'(bus.tx_in_ready), 64'd0);
      chk($sformatf("bp_hold%0d_out", i), 64'({bus.tx_out_valid, bus.tx_out_data}), 64'({1'b1, 8'h44}));
    end
    @(negedge clk);
    tx_or = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.tx_in_ready), 64'd1);
    @(posedge clk); #1;
    bus.tx_in_valid = 1'b0;
    chk("bp_b2b_out", 64'({bus.tx_out_valid, bus.tx_out_data}), 64'({1'b1, 8'h22}));
    @(posedge clk); #1;
    chk("bp_drain_valid", 64'(bus.tx_out_valid), 64'd0);

    // Loopback with random backpressure
    do_reset();
    lb = 1'b1; sent = 0; got = 0; acc = 1'b0;
    for (int cyc = 0; cyc < 3000 && got < 64; cyc++) begin
      @(negedge clk);
      if (acc || !bus.tx_in_valid) begin
        if (sent < 64) begin
          bus.tx_in_valid = 1'b1; bus.tx_in_data = 8'($urandom_range(0, 255));
        end else begin
          bus.tx_in_valid = 1'b0;
        end
      end
      bus.rx_out_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc = bus.tx_in_valid && bus.tx_in_ready;
      if (acc) begin
        q.push_back(bus.tx_in_data); sent++;
      end
      if (bus.rx_out_valid && bus.rx_out_ready) begin
        if (q.size() == 0) begin
          chk("lb_unexpected_beat", 64'(q.size()), 64'd1);
        end else begin
          exp_b = q.pop_front();
          chk($sformatf("lb_beat%0d", got), 64'(bus.rx_out_data), 64'(exp_b));
        end
        got++;
      end
    end
    @(negedge clk);
    bus.tx_in_valid = 1'b0; bus.rx_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("lb_count", 64'(got), 64'd64);
    chk("lb_leftover", 64'(q.size()), 64'd0);
    chk("lb_no_extra", 64'(bus.rx_out_valid), 64'd0);
    lb = 1'b0;

    // Config: bypass, default taps, seed 1
    shift_cfg({1'b1, 1'b0, 32'h48000000, 32'h00000001}, 66, 1, "cfg_bypass");
    chk("cfg_bypass_ok", 64'(cfg_ok), 64'd1);
    chk("cfg_bypass_err", 64'(cfg_err), 64'd0);
    send_tx(8'hA5, 8'hA5, 1'b0, "bypass_A5");

    // Bad loads then recovery
    shift_cfg({1'b0, 1'b0, 32'h48000000, 32'h00000055}, 65, 1, "short");
    chk("short_ok", 64'(cfg_ok), 64'd0);
    chk("short_err", 64'(cfg_err), 64'd1);
    bus.tx_in_valid = 1'b1; bus.tx_in_data = 8'h00;
    #1;
    chk("short_in_ready", 64'(bus.tx_in_ready), 64'd0);
    bus.tx_in_valid = 1'b0;
    shift_cfg({1'b0, 1'b0, 32'h48000000, 32'h00000000}, 66, -1, "zseed");
    chk("zseed_ok", 64'(cfg_ok), 64'd0);
    chk("zseed_err", 64'(cfg_err), 64'd1);
    shift_cfg({1'b0, 1'b0, 32'h48000000, 32'h00000055}, 66, -1, "restore");
    chk("restore_ok", 64'(cfg_ok), 64'd1);
    chk("restore_err", 64'(cfg_err), 64'd0);

    // Rekey concurrent with an accepted beat
    send_tx(8'hFF, 8'hAA, 1'b0, "rk_first");
    send_tx(8'h00, 8'h00, 1'b1, "rk_concurrent");
    send_tx(8'hFF, 8'hAA, 1'b0, "rk_after");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
